// File: rtl/spi_debug_tx_pkg.sv
// Shared types and constants for the SPI-style debug character transmitter.
//   spi_tx_state_t : transmitter FSM states
//   SPI_BYTE_BITS  : bits per transmitted character
package spi_debug_tx_pkg;

  localparam int unsigned SPI_BYTE_BITS = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOW  = 2'd1,
    HIGH = 2'd2
  } spi_tx_state_t;

endpackage : spi_debug_tx_pkg

// File: rtl/spi_debug_tx_fifo_sync.sv
// Synchronous FIFO with registered occupancy and status flags.
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   push, push_data   : write strobe and data (ignored while full)
//   pop, pop_data_c   : read strobe (ignored while empty) and head-of-queue data
//   full, empty       : registered status flags
//   count             : registered occupancy, 0..DEPTH
module fifo_sync #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data_c,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push_c;
  logic             do_pop_c;
  logic [CNT_W-1:0] count_next_c;

  // Qualified strobes and next occupancy; a simultaneous push and pop leaves it unchanged.
  always_comb begin
    do_push_c    = push && !full;
    do_pop_c     = pop && !empty;
    count_next_c = count;
    if (do_push_c && !do_pop_c) begin
      count_next_c = count + CNT_W'(1);
    end else if (!do_push_c && do_pop_c) begin
      count_next_c = count - CNT_W'(1);
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (do_push_c) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (do_pop_c) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      count <= count_next_c;
      full  <= (count_next_c == CNT_W'(DEPTH));
      empty <= (count_next_c == '0);
    end
  end

  // Storage needs no reset; it is only read when the occupancy says it is valid.
  always_ff @(posedge clk) begin
    if (do_push_c) begin
      mem[wr_ptr] <= push_data;
    end
  end

  assign pop_data_c = mem[rd_ptr];

endmodule : fifo_sync

// File: rtl/spi_debug_tx.sv
// Debug character transmitter: buffers bytes and shifts them out MSB-first
// on a free-running-per-byte serial clock with no chip select or framing.
// Ports:
//   clk, rst  : core clock, synchronous active-high reset
//   in_valid  : byte offered; accepted when in_valid && in_ready
//   in_data   : byte to send
//   in_ready  : FIFO not full
//   sclk      : serial clock (receiver samples on rising edge)
//   sdo       : serial data, changes only while sclk is low
//   busy      : FIFO non-empty or a byte in flight
module spi_debug_tx
  import spi_debug_tx_pkg::*;
#(
  parameter int unsigned CLK_DIV    = 2,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic [SPI_BYTE_BITS-1:0] in_data,
  output logic                     in_ready,
  output logic                     sclk,
  output logic                     sdo,
  output logic                     busy
);

  localparam int unsigned DIV_W = 8;
  localparam int unsigned BIT_W = $clog2(SPI_BYTE_BITS);
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

  spi_tx_state_t              state_q;
  spi_tx_state_t              state_d;
  logic [SPI_BYTE_BITS-1:0]   shreg;
  logic [DIV_W-1:0]           divcnt;
  logic [BIT_W-1:0]           bitcnt;

  logic                       fifo_full;
  logic                       fifo_empty;
  logic [CNT_W-1:0]           fifo_count;
  logic [SPI_BYTE_BITS-1:0]   fifo_data_c;

  logic                       div_done_c;
  logic                       last_bit_c;
  logic                       load_c;
  logic                       shift_c;
  logic                       div_clr_c;

  fifo_sync #(
    .WIDTH (SPI_BYTE_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (in_valid),
    .push_data  (in_data),
    .pop        (load_c),
    .pop_data_c (fifo_data_c),
    .full       (fifo_full),
    .empty      (fifo_empty),
    .count      (fifo_count)
  );

  assign div_done_c = (divcnt == DIV_W'(CLK_DIV - 1));
  assign last_bit_c = (bitcnt == BIT_W'(SPI_BYTE_BITS - 1));

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: each bit is CLK_DIV cycles LOW then CLK_DIV cycles HIGH.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          state_d = LOW;
        end
      end
      LOW: begin
        if (div_done_c) begin
          state_d = HIGH;
        end
      end
      HIGH: begin
        if (div_done_c) begin
          // A queued byte follows the last bit directly, keeping the clock period uniform.
          if (!last_bit_c || !fifo_empty) begin
            state_d = LOW;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath strobes decoded from the current state.
  always_comb begin
    load_c    = 1'b0;
    shift_c   = 1'b0;
    div_clr_c = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          load_c    = 1'b1;
          div_clr_c = 1'b1;
        end
      end
      LOW: begin
        if (div_done_c) begin
          div_clr_c = 1'b1;
        end
      end
      HIGH: begin
        if (div_done_c) begin
          div_clr_c = 1'b1;
          if (last_bit_c && !fifo_empty) begin
            load_c = 1'b1;
          end else begin
            shift_c = 1'b1;
          end
        end
      end
      default: begin
        div_clr_c = 1'b1;
      end
    endcase
  end

  // Divider, shift register and bit counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      divcnt <= '0;
      shreg  <= '0;
      bitcnt <= '0;
    end else begin
      if (div_clr_c) begin
        divcnt <= '0;
      end else if (state_q != IDLE) begin
        divcnt <= divcnt + DIV_W'(1);
      end

      if (load_c) begin
        shreg  <= fifo_data_c;
        bitcnt <= '0;
      end else if (shift_c) begin
        shreg  <= {shreg[SPI_BYTE_BITS-2:0], 1'b0};
        bitcnt <= bitcnt + BIT_W'(1);
      end
    end
  end

  // Serial outputs are registered from the next state so sclk tracks HIGH exactly
  // and sdo only moves on the transition into LOW; it holds its last value in IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      sclk <= 1'b0;
      sdo  <= 1'b0;
    end else begin
      sclk <= (state_d == HIGH);
      if (load_c) begin
        sdo <= fifo_data_c[SPI_BYTE_BITS-1];
      end else if (shift_c && (state_d == LOW)) begin
        sdo <= shreg[SPI_BYTE_BITS-2];
      end
    end
  end

  assign in_ready = !fifo_full;
  assign busy     = (state_q != IDLE) || (fifo_count != '0);

endmodule : spi_debug_tx

// File: doc/spi_debug_tx.md
Name: spi_debug_tx

Overview:
- Core-side serial debug transmitter; sends a character stream on two user GPIOs: serial clock on mprj_io[4], data on mprj_io[1].
- Accepts bytes through a valid/ready push interface and buffers them in a small FIFO.
- Shifts each byte out MSB-first. The far end samples data on each rising serial-clock edge and emits one character per 8 bits.
- No chip select and no framing. Byte alignment depends only on an exact bit count from reset.

Parameters:
- CLK_DIV, 2: serial-clock half-period in clk cycles; legal range 1..255.
- FIFO_DEPTH, 4: byte buffer entries; power of two, at least 2.

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  byte offered
- in_data  in  8  byte to send
- in_ready  out  1  FIFO can accept; a push occurs when in_valid && in_ready at a clk rising edge
- sclk  out  1  serial clock to mprj_io[4]
- sdo  out  1  serial data to mprj_io[1]
- busy  out  1  FIFO non-empty or a byte is in flight

Behaviour:
- Interface: single clock; reset is synchronous and active-high, sampled on the rising edge of clk.
- Reset values:
  - sclk=0, sdo=0, busy=0, in_ready=1.
  - FIFO is emptied; FSM goes to IDLE; shift register and counters are cleared.
- FIFO:
  - in_ready = !full, registered occupancy; there is no same-cycle pass-through.
  - Push and pop in the same cycle are both honoured, and occupancy is unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
  - in_data is ignored when in_valid=0. A push attempted while full is dropped, because in_ready is low.
- FSM states: IDLE, LOW, HIGH.
  - IDLE: sclk=0, sdo holds its last value. If the FIFO is non-empty: pop, load the 8-bit shift register, set bitcnt=0, set divcnt=0, go to LOW.
  - LOW: sclk=0, sdo=shreg[7]. When divcnt reaches CLK_DIV-1, clear divcnt and go to HIGH.
  - HIGH: sclk=1, sdo is held stable for the whole high phase. When divcnt reaches CLK_DIV-1:
    - shift shreg left by one and increment bitcnt;
    - if bitcnt was 7 and the FIFO is non-empty: pop and reload directly, go to LOW (back-to-back, no gap cycle);
    - if bitcnt was 7 and the FIFO is empty: go to IDLE;
    - otherwise go to LOW.
- Timing:
  - Each bit is CLK_DIV cycles low followed by CLK_DIV cycles high; one byte takes 16*CLK_DIV cycles.
  - Latency from an accepted push into an empty FIFO in an idle block:
    - cycle N+1: FIFO non-empty, pop in IDLE;
    - cycle N+2: LOW entered, sdo = bit7;
    - first sclk rising edge at cycle N+2+CLK_DIV.
- sdo changes only in the cycle sclk goes low, or on entering LOW from IDLE. It never changes while sclk=1.
- busy = (state != IDLE) || !empty.
- Reset mid-byte:
  - sclk=0 in the next cycle; the partial byte and all FIFO contents are discarded.
  - The downstream bit alignment is lost; this is accepted, and the system resets both ends together.
- Counters: divcnt is 8 bits and bitcnt is 3 bits; both wrap only under FSM control.

Decomposition:
- Shared package holds:
  - the state enum spi_tx_state_t {IDLE, LOW, HIGH};
  - the SPI_BYTE_BITS=8 constant.
- One sub-module: fifo_sync, a parameterised width/depth synchronous FIFO with push/pop/full/empty and registered occupancy. It is reusable by other blocks.
- Top level contains the FSM, divider and shift register.

Test Plan:
1. CLK_DIV=2: push 0x41 once.
   - 8 sclk rising edges, spaced exactly 4 cycles apart.
   - sdo sampled at each edge = 0,1,0,0,0,0,0,1.
   - First edge at cycle N+4; busy low 32 cycles after entering LOW.
2. Push "Hi\n" (0x48, 0x69, 0x0A) on consecutive cycles.
   - 24 rising edges with a uniform 4-cycle period and no extra gap between bytes.
   - A receiver model prints "Hi\n".
3. FIFO_DEPTH=4: hold in_valid high with 6 bytes.
   - in_ready deasserts after the 5th accepted byte (1 in shifter, 4 queued).
   - It reasserts in the cycle after the next pop.
   - All 6 bytes are emitted in order, with none lost or duplicated.
4. Assert rst for 1 cycle during bit 3 of 0xA5.
   - Next cycle: sclk=0, sdo=0, busy=0, in_ready=1.
   - No further edges occur until a new push; the new byte 0x55 is emitted intact.
5. CLK_DIV=1: push 0xFF, then 0x00.
   - sclk toggles every cycle.
   - sdo reads 1 for 8 edges, then 0 for 8 edges.
   - sdo is stable during every high phase.
6. Simultaneous push and pop with 2 entries queued: occupancy stays 2, and output order is preserved.
